// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 captures the request; stage 2 computes and holds result/flags
// until the consumer takes them.
module alu_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_ADC = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  logic             r_s1Valid;
  logic [3:0]       r_s1Op;
  logic [WIDTH-1:0] r_s1A;
  logic [WIDTH-1:0] r_s1B;

  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_illegal;
  logic             r_isNop;
  logic             r_carryQ;

  logic               w_s2Load;
  logic               w_inAccept;
  logic               w_outAccept;
  logic [SHAMT_W-1:0] w_sh;
  logic               w_carryIn;
  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH:0]     w_sra;
  logic               w_ovAdd;
  logic               w_ovSub;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_nzSrc;
  logic               w_c;
  logic               w_v;
  logic               w_ill;
  logic               w_nop;
  logic [3:0]         w_flags;

  assign w_s2Load    = r_s1Valid & (~r_outValid | out_ready);
  assign in_ready    = ~r_s1Valid | w_s2Load;
  assign w_inAccept  = in_valid & in_ready;
  assign w_outAccept = r_outValid & out_ready;

  // ADC must see the carry of a beat leaving S2 in this same cycle, so the
  // outgoing C flag is forwarded ahead of the carry register update.
  assign w_carryIn = (w_outAccept & ~r_isNop) ? r_flags[1] : r_carryQ;
  assign w_cin     = (r_s1Op == OP_ADC) & w_carryIn;

  assign w_sh     = r_s1B[SHAMT_W-1:0];
  assign w_sum    = {1'b0, r_s1A} + {1'b0, r_s1B} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff   = r_s1A - r_s1B;
  assign w_borrow = (r_s1A < r_s1B);
  assign w_ovAdd  = (r_s1A[WIDTH-1] == r_s1B[WIDTH-1]) & (w_sum[WIDTH-1] != r_s1A[WIDTH-1]);
  assign w_ovSub  = (r_s1A[WIDTH-1] != r_s1B[WIDTH-1]) & (w_diff[WIDTH-1] != r_s1A[WIDTH-1]);

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
  assign w_shl = {1'b0, r_s1A} << w_sh;
  assign w_shr = {r_s1A, 1'b0} >> w_sh;
  assign w_sra = $signed({r_s1A, 1'b0}) >>> w_sh;

  // Operation decode and flag formation for the beat sitting in S1.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    w_nop = 1'b0;
    case (r_s1Op)
      OP_NOP: w_nop = 1'b1;
      OP_ADD, OP_ADC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_ovAdd;
      end
      OP_SUB: begin
        w_res = w_diff;
        w_c   = w_borrow;
        w_v   = w_ovSub;
      end
      OP_AND: w_res = r_s1A & r_s1B;
      OP_OR:  w_res = r_s1A | r_s1B;
      OP_XOR: w_res = r_s1A ^ r_s1B;
      OP_NOT: w_res = ~r_s1A;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_SRA: begin
        w_res = w_sra[WIDTH:1];
        w_c   = w_sra[0];
      end
      OP_CMP: begin
        w_c = w_borrow;
        w_v = w_ovSub;
      end
      default: w_ill = 1'b1;
    endcase
    w_nzSrc = (r_s1Op == OP_CMP) ? w_diff : w_res;
    if (w_nop) begin
      w_flags = r_flags;
    end else if (w_ill) begin
      w_flags = 4'b0000;
    end else begin
      w_flags = {w_nzSrc[WIDTH-1], (w_nzSrc == '0), w_c, w_v};
    end
  end

  // Stage 1: capture the request on accept, empty when it moves into S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Op    <= '0;
      r_s1A     <= '0;
      r_s1B     <= '0;
    end else if (w_inAccept) begin
      r_s1Valid <= 1'b1;
      r_s1Op    <= opcode;
      r_s1A     <= operand1;
      r_s1B     <= operand2;
    end else if (w_s2Load) begin
      r_s1Valid <= 1'b0;
    end
  end

  // Stage 2: register the computed beat and hold it until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
      r_illegal  <= 1'b0;
      r_isNop    <= 1'b0;
    end else if (w_s2Load) begin
      r_outValid <= 1'b1;
      r_result   <= w_res;
      r_flags    <= w_flags;
      r_illegal  <= w_ill;
      r_isNop    <= w_nop;
    end else if (w_outAccept) begin
      r_outValid <= 1'b0;
    end
  end

  // Carry for ADC tracks the C flag of each delivered beat, NOPs excluded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carryQ <= 1'b0;
    end else if (w_outAccept & ~r_isNop) begin
      r_carryQ <= r_flags[1];
    end
  end

  assign out_valid = r_outValid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: single beats, back-to-back carry chaining,
// a back-pressured stream and reset with beats in flight.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        illegal;

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .illegal(illegal)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    opcode   = op;
    operand1 = a;
    operand2 = b;
  endtask

  task automatic idleInputs();
    in_valid = 1'b0;
    opcode   = 4'hE;
    operand1 = 32'hDEAD_BEEF;
    operand2 = 32'hCAFE_F00D;
  endtask

  task automatic runSingle(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expRes,
                           input logic [3:0] expFlags, input logic expIll);
    out_ready = 1'b1;
    applyStimulus(op, a, b);
    settle();
    checkOutput({tag, ".inReady"}, {31'b0, in_ready}, 32'd1);
    tick();
    idleInputs();
    settle();
    checkOutput({tag, ".validEarly"}, {31'b0, out_valid}, 32'd0);
    tick();
    checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({tag, ".result"}, result, expRes);
    checkOutput({tag, ".flags"}, {28'b0, flags}, {28'b0, expFlags});
    checkOutput({tag, ".illegal"}, {31'b0, illegal}, {31'b0, expIll});
    tick();
    checkOutput({tag, ".drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  logic [3:0]  streamOp  [8];
  logic [31:0] streamA   [8];
  logic [31:0] streamB   [8];
  logic [31:0] streamExp [8];

  initial begin
    int          sent;
    int          recv;
    logic        stalledPrev;
    logic [31:0] heldRes;
    logic        expRdy;

    streamOp[0] = 4'd1; streamA[0] = 32'h1;        streamB[0] = 32'h2;        streamExp[0] = 32'h3;
    streamOp[1] = 4'd2; streamA[1] = 32'd10;       streamB[1] = 32'd4;        streamExp[1] = 32'd6;
    streamOp[2] = 4'd3; streamA[2] = 32'hF0F0;     streamB[2] = 32'hFF00;     streamExp[2] = 32'hF000;
    streamOp[3] = 4'd4; streamA[3] = 32'h0F00;     streamB[3] = 32'h00F0;     streamExp[3] = 32'h0FF0;
    streamOp[4] = 4'd5; streamA[4] = 32'h0000FFFF; streamB[4] = 32'h00000F0F; streamExp[4] = 32'h0000F0F0;
    streamOp[5] = 4'd6; streamA[5] = 32'h0;        streamB[5] = 32'h0;        streamExp[5] = 32'hFFFFFFFF;
    streamOp[6] = 4'd7; streamA[6] = 32'h1;        streamB[6] = 32'h4;        streamExp[6] = 32'h10;
    streamOp[7] = 4'd8; streamA[7] = 32'h180;      streamB[7] = 32'h8;        streamExp[7] = 32'h1;

    rst       = 1'b1;
    out_ready = 1'b0;
    idleInputs();
    tick();
    tick();
    checkOutput("reset.outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset.result", result, 32'h0);
    checkOutput("reset.flags", {28'b0, flags}, 32'h0);
    checkOutput("reset.illegal", {31'b0, illegal}, 32'd0);
    checkOutput("reset.inReady", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    tick();

    runSingle("addWrap", 4'd1, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0110, 1'b0);

    // Back-to-back ADD then ADC: carry must forward from the beat leaving S2.
    out_ready = 1'b1;
    applyStimulus(4'd1, 32'hFFFFFFFF, 32'h0);
    tick();
    applyStimulus(4'd10, 32'h0, 32'h0);
    settle();
    checkOutput("chain1.inReady", {31'b0, in_ready}, 32'd1);
    tick();
    idleInputs();
    checkOutput("chain1.addResult", result, 32'hFFFFFFFF);
    checkOutput("chain1.addFlags", {28'b0, flags}, {28'b0, 4'b1000});
    tick();
    checkOutput("chain1.adcResult", result, 32'h0);
    checkOutput("chain1.adcFlags", {28'b0, flags}, {28'b0, 4'b0100});
    tick();

    applyStimulus(4'd1, 32'hFFFFFFFF, 32'h1);
    tick();
    applyStimulus(4'd10, 32'h5, 32'h5);
    tick();
    idleInputs();
    checkOutput("chain2.addFlags", {28'b0, flags}, {28'b0, 4'b0110});
    tick();
    checkOutput("chain2.adcResult", result, 32'hB);
    checkOutput("chain2.adcFlags", {28'b0, flags}, {28'b0, 4'b0000});
    tick();

    runSingle("subOvf", 4'd2, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0001, 1'b0);
    runSingle("cmp", 4'd11, 32'h3, 32'h5, 32'h0, 4'b1010, 1'b0);
    runSingle("nop", 4'd0, 32'h12, 32'h34, 32'h0, 4'b1010, 1'b0);
    runSingle("adcAfterNop", 4'd10, 32'h1, 32'h1, 32'h3, 4'b0000, 1'b0);
    runSingle("sra", 4'd9, 32'h80000000, 32'h4, 32'hF8000000, 4'b1000, 1'b0);
    runSingle("shl", 4'd7, 32'h80000001, 32'h1, 32'h00000002, 4'b0010, 1'b0);
    runSingle("shrZero", 4'd8, 32'h12345678, 32'h0, 32'h12345678, 4'b0000, 1'b0);
    runSingle("shrMasked", 4'd8, 32'h3, 32'h21, 32'h1, 4'b0010, 1'b0);
    runSingle("illegal", 4'd13, 32'h5, 32'h6, 32'h0, 4'b0000, 1'b1);

    // Stream eight beats while out_ready cycles 1,0,0.
    sent        = 0;
    recv        = 0;
    stalledPrev = 1'b0;
    heldRes     = '0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      out_ready = (cyc % 3 == 0);
      if (sent < 8) applyStimulus(streamOp[sent], streamA[sent], streamB[sent]);
      else idleInputs();
      settle();
      if (stalledPrev) begin
        checkOutput("stream.holdValid", {31'b0, out_valid}, 32'd1);
        checkOutput("stream.holdResult", result, heldRes);
      end
      expRdy = ((sent - recv) < 2) || out_ready;
      checkOutput($sformatf("stream.inReady%0d", cyc), {31'b0, in_ready}, {31'b0, expRdy});
      if (out_valid && out_ready) begin
        checkOutput($sformatf("stream.result%0d", recv), result, streamExp[recv]);
        recv++;
      end
      stalledPrev = out_valid && !out_ready;
      heldRes     = result;
      if (in_valid && in_ready) sent++;
      tick();
    end
    idleInputs();
    checkOutput("stream.count", recv, 32'd8);

    // Two beats in flight (illegal in S2, ADD in S1) when reset hits.
    out_ready = 1'b0;
    applyStimulus(4'd13, 32'h1, 32'h1);
    tick();
    applyStimulus(4'd1, 32'h5, 32'h1);
    tick();
    idleInputs();
    settle();
    checkOutput("inflight.valid", {31'b0, out_valid}, 32'd1);
    checkOutput("inflight.illegal", {31'b0, illegal}, 32'd1);
    checkOutput("inflight.inReady", {31'b0, in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midReset.outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("midReset.illegal", {31'b0, illegal}, 32'd0);
    checkOutput("midReset.inReady", {31'b0, in_ready}, 32'd1);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("postReset.noStale", {31'b0, out_valid}, 32'd0);
    runSingle("postReset.adc", 4'd10, 32'h2, 32'h3, 32'h5, 4'b0000, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
